// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 handshake selector and its round-robin picker.
package mux_pkg;

  localparam int MUX_DEF_WIDTH = 32;

  typedef enum logic [0:0] {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  // Index width for a channel count; at least 1 bit so a 2-entry select is representable.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_nto1_hs_rr_pick.sv
// Rotating-priority picker: grants the first requester strictly after base, wrapping at NUM_IN.
module rr_pick
  import mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  base,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [SEL_W:0] cand_s;

  // Scan base+1 .. base+NUM_IN modulo NUM_IN; the last candidate is base itself.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= NUM_IN; i++) begin
      cand_s = {1'b0, base} + (SEL_W+1)'(i);
      if (cand_s >= (SEL_W+1)'(NUM_IN)) begin
        cand_s = cand_s - (SEL_W+1)'(NUM_IN);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_vld && req[cand_s[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_s[SEL_W-1:0];
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_hs.sv
// N-to-1 valid/ready selector with a one-entry registered output stage.
// Round-robin selection (rr_mode_i port, rr_ptr state) is built only when MUX_RR_EN is defined.
module mux_nto1_hs
  import mux_pkg::*;
#(
  parameter int WIDTH  = MUX_DEF_WIDTH,
  parameter int NUM_IN = 4,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [NUM_IN-1:0]       valid_i,
  output logic [NUM_IN-1:0]       ready_o,
  input  logic [SEL_W-1:0]        sel_i,
`ifdef MUX_RR_EN
  input  logic                    rr_mode_i,
`endif
  output logic [WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  logic [WIDTH-1:0]  data_r;
  logic [SEL_W-1:0]  sel_r;
  logic              valid_r;
  logic              free_s;
  logic              xfer_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic              grant_vld_s;
  logic [NUM_IN-1:0] ready_s;
  logic [WIDTH-1:0]  sel_data_s;

  assign free_s = !valid_r || ready_i;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_r;
  logic [SEL_W-1:0] rr_idx_s;
  logic             rr_vld_s;
  mux_mode_e        mode_s;

  assign mode_s = mux_mode_e'(rr_mode_i);

  rr_pick #(.NUM_IN(NUM_IN)) u_rr_pick (
    .req     (valid_i),
    .base    (rr_ptr_r),
    .gnt_idx (rr_idx_s),
    .gnt_vld (rr_vld_s)
  );

  // Grant source: round-robin picker or explicit select.
  always_comb begin
    case (mode_s)
      MODE_RR: begin
        grant_idx_s = rr_idx_s;
        grant_vld_s = rr_vld_s;
      end
      MODE_SEL: begin
        grant_idx_s = sel_i;
        grant_vld_s = ({1'b0, sel_i} < (SEL_W+1)'(NUM_IN));
      end
      default: begin
        grant_idx_s = '0;
        grant_vld_s = 1'b0;
      end
    endcase
  end

  // Priority pointer advances to the winner only when a word actually moves.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr_r <= SEL_W'(NUM_IN - 1);
    end else if (xfer_s) begin
      rr_ptr_r <= grant_idx_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Explicit select only; out-of-range indices grant nothing.
  always_comb begin
    grant_idx_s = sel_i;
    grant_vld_s = ({1'b0, sel_i} < (SEL_W+1)'(NUM_IN));
  end
`endif

  // Ready decode and data steering; ready depends only on handshake state, never on data_i.
  always_comb begin
    ready_s    = '0;
    sel_data_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (rst_i && free_s && grant_vld_s && (grant_idx_s == SEL_W'(k)) && valid_i[k]) begin
        ready_s[k] = 1'b1;
        sel_data_s = data_i[k*WIDTH +: WIDTH];
      end else begin
        ready_s[k] = 1'b0;
      end
    end
  end

  assign xfer_s = |ready_s;

  // One-entry output register: load on transfer, drain when consumed with nothing new.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_r  <= '0;
      sel_r   <= '0;
      valid_r <= 1'b0;
    end else if (xfer_s) begin
      data_r  <= sel_data_s;
      sel_r   <= grant_idx_s;
      valid_r <= 1'b1;
    end else if (free_s) begin
      data_r  <= data_r;
      sel_r   <= sel_r;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      sel_r   <= sel_r;
      valid_r <= valid_r;
    end
  end

  assign ready_o = ready_s;
  assign data_o  = data_r;
  assign sel_o   = sel_r;
  assign valid_o = valid_r;

endmodule
